// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard scoreboard for the register-read stage.
// Tracks per-register pending destination writes and a total in-flight count,
// and raises a combinational stall when the presented instruction would read
// a pending register or cannot allocate a new pending write.
module hazard_scoreboard #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned TOT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IR,
    input  logic             v_in,
    input  logic             r_out,
    input  logic             v_wb,
    input  logic [4:0]       WB_address,
    input  logic             squash_valid,
    input  logic [4:0]       squash_rd,
    output logic             stall,
    output logic [31:0]      busy_vec,
    output logic [TOT_W-1:0] inflight,
    output logic             err
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [TOT_W-1:0] TotMax = TOT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] count_q [32];
    logic [CNT_W-1:0] count_d [32];
    logic [TOT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs1, uses_rs2, writes_rd;
    logic       hazard_rs1, hazard_rs2, alloc_block;
    logic       issue, alloc;

    // Function bits and immediate fields are irrelevant to hazard tracking.
    logic unused_ir;
    assign unused_ir = ^{IR[31:25], IR[14:12]};

    assign opcode = IR[6:0];
    assign rs1    = IR[19:15];
    assign rs2    = IR[24:20];
    assign rd     = IR[11:7];

    // Opcode decode into source-use and destination-write flags.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal: begin
                writes_rd = 1'b1;
            end
            OpJalr, OpLoad, OpImm: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OpBranch, OpStore: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OpReg: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard and allocation checks; a same-cycle writeback of the last pending
    // write is forwarded by the read stage, so it does not stall a source.
    always_comb begin
        hazard_rs1 = uses_rs1 && (rs1 != 5'd0) && (count_q[rs1] != '0) &&
                     !(v_wb && (WB_address == rs1) && (count_q[rs1] == CntOne));
        hazard_rs2 = uses_rs2 && (rs2 != 5'd0) && (count_q[rs2] != '0) &&
                     !(v_wb && (WB_address == rs2) && (count_q[rs2] == CntOne));
        // Same-cycle releases are deliberately ignored to keep this path short.
        alloc_block = writes_rd && (rd != 5'd0) &&
                      ((count_q[rd] == CntMax) || (inflight_q == TotMax));
        stall = v_in && (hazard_rs1 || hazard_rs2 || alloc_block);
        issue = v_in && r_out && !stall;
        alloc = issue && writes_rd && (rd != 5'd0);
    end

    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   dec;
    logic [CNT_W:0]   applied;
    logic [TOT_W-1:0] dec_tot;

    // Per-register net update with clamp-at-zero; inflight follows the
    // decrements actually applied so it always equals the sum of counts.
    always_comb begin
        count_d[0] = '0;
        err_d      = err_q;
        dec_tot    = '0;
        sum        = '0;
        dec        = '0;
        applied    = '0;
        for (int r = 1; r < 32; r++) begin
            sum = {1'b0, count_q[r]} + (CNT_W + 1)'(alloc && (rd == 5'(r)));
            dec = (CNT_W + 1)'(v_wb && (WB_address == 5'(r))) +
                  (CNT_W + 1)'(squash_valid && (squash_rd == 5'(r)));
            if (sum < dec) begin
                count_d[r] = '0;
                err_d      = 1'b1;
                applied    = sum;
            end else begin
                count_d[r] = CNT_W'(sum - dec);
                applied    = dec;
            end
            dec_tot = dec_tot + TOT_W'(applied);
        end
        inflight_d = inflight_q + TOT_W'(alloc) - dec_tot;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '{default: '0};
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Busy flags derived from the counters; x0 is never busy.
    always_comb begin
        busy_vec[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            busy_vec[r] = (count_q[r] != '0);
        end
    end

    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Sequences the register-read stage by detecting read-after-write hazards on in-flight instructions and raising the stall input of the read stage.
- Keeps a per-register count of issued-but-not-written-back destination writes. Increments on issue from the read stage; decrements on writeback or squash.
- Sits beside the read stage: observes its IR, v_in and r_out, and drives its stall.

Parameters:
- CNT_W, 2, width of each per-register pending counter; max per-register outstanding = 2^CNT_W-1.
- MAX_INFLIGHT, 8, cap on total outstanding register-writing instructions.
- TOT_W, 4, width of the total in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- IR  in  32  instruction currently presented to the read stage.
- v_in  in  1  IR is valid.
- r_out  in  1  read stage ready flag; issue = v_in & r_out & ~stall.
- v_wb  in  1  writeback valid this cycle.
- WB_address  in  5  writeback destination register.
- squash_valid  in  1  an issued instruction was killed before writeback.
- squash_rd  in  5  destination register of the killed instruction.
- stall  out  1  combinational hazard stall to the read stage.
- busy_vec  out  32  bit r set when count[r] != 0; bit 0 always 0.
- inflight  out  TOT_W  total outstanding register writes.
- err  out  1  sticky error: decrement of a zero counter.

Behaviour:
- Reset (async, immediate): all counts = 0, inflight = 0, err = 0. busy_vec = 0 and stall = 0 follow combinationally.
- Decode from IR[6:0]:
  - uses_rs1 for JALR 1100111, LOAD 0000011, OP-IMM 0010011, BRANCH 1100011, STORE 0100011, OP 0110011.
  - uses_rs2 for BRANCH, STORE, OP.
  - writes_rd for LUI 0110111, AUIPC 0010111, JAL 1101111, JALR, LOAD, OP-IMM, OP.
  - Any other opcode: none of the three; it never stalls and never allocates.
- Register fields: rs1 = IR[19:15], rs2 = IR[24:20], rd = IR[11:7]. Register x0 never counts, never stalls, and never allocates.
- Per source s, hazard_s = uses_s & s != 0 & count[s] != 0, except when the read stage's WB forward covers it: v_wb & WB_address == s & count[s] == 1 clears hazard_s.
- stall = v_in & (hazard_rs1 | hazard_rs2 | alloc_block). stall is 0 when v_in = 0.
- alloc_block = writes_rd & rd != 0 & (count[rd] == 2^CNT_W-1 | inflight == MAX_INFLIGHT). Writeback or squash in the same cycle does not relieve alloc_block; the decision is conservative.
- Stall has zero latency: it is evaluated the same cycle IR is presented and sampled by the read stage at posedge.
- On posedge, for each register r, compute net = inc - dec_wb - dec_sq:
  - inc = issue & writes_rd & rd == r.
  - dec_wb = v_wb & WB_address == r.
  - dec_sq = squash_valid & squash_rd == r.
  - Apply net to count[r] and the summed net to inflight. Simultaneous inc and dec on the same register leaves the count unchanged.
- Writeback or squash to r = 0 is ignored.
- Decrement of a counter that is already 0 (including wb and squash both hitting a count of 1): clamp at 0, set err = 1. err stays set until rst.
- inflight never wraps; it tracks the sum of all counts.
- Reset asserted mid-stall releases stall asynchronously. Instructions already in flight are forgotten, so later writebacks for them set err; the bench asserts rst only with the pipeline drained.

Test Plan:
- Reset then idle with v_in = 0 -> stall = 0, busy_vec = 0, inflight = 0, err = 0.
- Issue ADDI x5,x0,1 (IR 0x00100293) with r_out = 1, then present ADD x6,x5,x5 (0x00528333) -> busy_vec[5] = 1, stall = 1 until a cycle with v_wb = 1 and WB_address = 5; stall drops in that same cycle; busy_vec[5] = 0 next cycle.
- Issue LUI x7 three times with no writeback and CNT_W = 2, then present a fourth LUI x7 -> count[7] = 3, stall = 1 on the fourth. One WB to x7 -> the next cycle the fourth issues and count stays 3.
- Issue 8 writes to distinct registers, then present a 9th -> inflight = 8, stall = 1. A SW x0,0(x0) (0x00002023) with no busy source -> stall = 0.
- Same cycle: issue ADDI x9 while v_wb = 1 and WB_address = 9 with count[9] = 1 -> count[9] stays 1, inflight unchanged.
- v_wb = 1 with WB_address = 12 and count[12] = 0 -> err = 1, count[12] = 0. Then rst pulse mid-cycle -> err = 0 immediately.
